// File: rtl/i3c_phy_filtered.sv
// I3C pad PHY: configurable-depth synchroniser, runtime spike filter, edge strobes, OD/PP drive.
// Defining I3C_PHY_STUCK_DETECT_EN adds the SCL stuck-low detector (stuck_o tied 0 otherwise).
module i3c_phy_filtered #(
  parameter int SyncStages  = 2,
  parameter int FiltCntW    = 4,
  parameter int StuckCycles = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scl_i,
  output logic                scl_o,
  output logic                scl_en_o,
  input  logic                sda_i,
  output logic                sda_o,
  output logic                sda_en_o,
  input  logic                ctrl_scl_i,
  input  logic                ctrl_sda_i,
  input  logic                pp_mode_i,
  input  logic [FiltCntW-1:0] filt_len_i,
  output logic                ctrl_scl_o,
  output logic                ctrl_sda_o,
  output logic                scl_rise_o,
  output logic                scl_fall_o,
  output logic                sda_rise_o,
  output logic                sda_fall_o,
  output logic                stuck_o
);

  // Line index 0 is SCL, 1 is SDA throughout.
  logic [SyncStages-1:0]        scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [1:0]                   line_sync;
  logic [1:0]                   fv_q, fv_d, fv_prev_q, fv_prev_d;
  logic [1:0][FiltCntW-1:0]     cnt_q, cnt_d;
  logic [1:0]                   rise_q, rise_d, fall_q, fall_d;
  logic                         scl_en_q, scl_en_d, sda_en_q, sda_en_d, sda_out_q, sda_out_d;

  assign line_sync = {sda_sync_q[SyncStages-1], scl_sync_q[SyncStages-1]};

  always_comb begin
    scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_i};
    fv_d       = fv_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (line_sync[i] != fv_q[i]) begin
        // >= rather than == so a lowered filt_len_i still commits without wrapping cnt.
        if (cnt_q[i] >= filt_len_i) begin
          fv_d[i]  = line_sync[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    fv_prev_d = fv_q;
    rise_d    = fv_q & ~fv_prev_q;
    fall_d    = ~fv_q & fv_prev_q;
    scl_en_d  = ~ctrl_scl_i;
    sda_en_d  = pp_mode_i | ~ctrl_sda_i;
    sda_out_d = pp_mode_i & ctrl_sda_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      fv_q       <= '1;
      fv_prev_q  <= '1;
      cnt_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      scl_en_q   <= 1'b0;
      sda_en_q   <= 1'b0;
      sda_out_q  <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      fv_q       <= fv_d;
      fv_prev_q  <= fv_prev_d;
      cnt_q      <= cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      scl_en_q   <= scl_en_d;
      sda_en_q   <= sda_en_d;
      sda_out_q  <= sda_out_d;
    end
  end

  assign scl_o      = 1'b0;
  assign scl_en_o   = scl_en_q;
  assign sda_o      = sda_out_q;
  assign sda_en_o   = sda_en_q;
  // Our own low drive is reported immediately instead of waiting for it to echo through the filter.
  assign ctrl_scl_o = fv_q[0] & ~scl_en_q;
  assign ctrl_sda_o = (sda_en_q && !sda_out_q) ? 1'b0 : fv_q[1];
  assign scl_rise_o = rise_q[0];
  assign scl_fall_o = fall_q[0];
  assign sda_rise_o = rise_q[1];
  assign sda_fall_o = fall_q[1];

`ifdef I3C_PHY_STUCK_DETECT_EN
  localparam int StuckW = $clog2(StuckCycles + 1);
  logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic              stuck_q, stuck_d;

  always_comb begin
    stuck_cnt_d = '0;
    if (!fv_q[0]) begin
      stuck_cnt_d = (stuck_cnt_q == StuckW'(StuckCycles)) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
    end
    stuck_d = !fv_q[0] && (stuck_cnt_d == StuckW'(StuckCycles));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      stuck_q     <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = 1'b0;
`endif

endmodule

// File: tb/tb_i3c_phy_filtered.sv
// Bench for i3c_phy_filtered: reset, filter pulses, strobes, drive table, stuck detector, random vs window model.
module tb_i3c_phy_filtered;
  localparam int SS   = 2;
  localparam int FCW  = 4;
  localparam int STK  = 16;
  localparam int MAXT = 2100;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           scl_i, sda_i, ctrl_scl_i, ctrl_sda_i, pp_mode_i;
  logic [FCW-1:0] filt_len_i;
  logic           scl_o, scl_en_o, sda_o, sda_en_o, ctrl_scl_o, ctrl_sda_o;
  logic           scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o, stuck_o;

  int checks = 0;
  int errors = 0;

  i3c_phy_filtered #(.SyncStages(SS), .FiltCntW(FCW), .StuckCycles(STK)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .scl_i(scl_i), .scl_o(scl_o), .scl_en_o(scl_en_o),
    .sda_i(sda_i), .sda_o(sda_o), .sda_en_o(sda_en_o),
    .ctrl_scl_i(ctrl_scl_i), .ctrl_sda_i(ctrl_sda_i), .pp_mode_i(pp_mode_i),
    .filt_len_i(filt_len_i),
    .ctrl_scl_o(ctrl_scl_o), .ctrl_sda_o(ctrl_sda_o),
    .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
    .sda_rise_o(sda_rise_o), .sda_fall_o(sda_fall_o),
    .stuck_o(stuck_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic c_scl, c_sda, pp;
    logic e_scl_en, e_sda_en, e_sda_o, e_cscl, e_csda;
  } drv_vec_t;

  drv_vec_t tbl [10];

  // Reference model storage, indexed by clock edge number since the last reset.
  logic pad_h  [2][0:MAXT-1];
  logic seen_h [2][0:MAXT-1];
  logic fv_h   [2][0:MAXT-1];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {scl_o, scl_en_o, sda_o, sda_en_o, ctrl_scl_o, ctrl_sda_o,
            scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o, stuck_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that counts as edge 0.
  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  function automatic logic padval(input int k);
    if (k < 1) return 1'b1;
    return (((k - 1) % 8) < 4) ? 1'b0 : 1'b1;
  endfunction

  task automatic sda_pulse(input int len);
    logic e_fv;
    for (int c = 1; c <= 14; c++) begin
      sda_i = (c <= len) ? 1'b0 : 1'b1;
      tick();
      e_fv = !((len >= 4) && (c >= 6) && (c <= len + 5));
      check1($sformatf("pulse%0d.ctrl_sda c%0d", len, c), ctrl_sda_o, e_fv);
      check1($sformatf("pulse%0d.sda_fall c%0d", len, c), sda_fall_o, (len >= 4) && (c == 7));
      check1($sformatf("pulse%0d.sda_rise c%0d", len, c), sda_rise_o, (len >= 4) && (c == len + 7));
    end
  endtask

  task automatic stuck_run(input string name, input int from, input int to, input int set_at, input int clr_at);
    logic e;
    for (int c = from; c <= to; c++) begin
      tick();
`ifdef I3C_PHY_STUCK_DETECT_EN
      e = (c >= set_at) && (c < clr_at);
`else
      e = 1'b0;
`endif
      check1($sformatf("%s c%0d", name, c), stuck_o, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] e_vec;
    logic        cs, cd, pp, e_scl_en, e_sda_en, e_sda_o, mism, e_stuck;
    logic [1:0]  e_r, e_f;
    int          n, run, t;
    int          segn [5];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    segn = '{0, 2, 5, 1, -1};

    scl_i = 1'b1; sda_i = 1'b1; ctrl_scl_i = 1'b1; ctrl_sda_i = 1'b1;
    pp_mode_i = 1'b0; filt_len_i = 4'd3; rst_ni = 1'b1;

    // Reset state, observed asynchronously before any clock edge.
    #2;
    rst_ni = 1'b0;
    #1;
    checkv("reset.async", outs(), 11'b0000_11_0000_0);
    do_reset();
    checkv("reset.released", outs(), 11'b0000_11_0000_0);

    // Spike filter with N=3.
    sda_pulse(3);
    sda_pulse(4);

    // N=0 square wave on SCL, period 8.
    filt_len_i = 4'd0;
    for (int c = 1; c <= 32; c++) begin
      scl_i = padval(c);
      tick();
      check1($sformatf("sq.ctrl_scl c%0d", c), ctrl_scl_o, padval(c - 2));
      check1($sformatf("sq.scl_fall c%0d", c), scl_fall_o, (c % 8) == 4);
      check1($sformatf("sq.scl_rise c%0d", c), scl_rise_o, (c % 8) == 0);
    end
    scl_i = 1'b1;
    repeat (4) tick();

    // Drive path table, pads idle high.
    for (int i = 0; i < 10; i++) begin
      ctrl_scl_i = tbl[i].c_scl;
      ctrl_sda_i = tbl[i].c_sda;
      pp_mode_i  = tbl[i].pp;
      tick();
      check1($sformatf("drv[%0d].scl_en", i), scl_en_o, tbl[i].e_scl_en);
      check1($sformatf("drv[%0d].sda_en", i), sda_en_o, tbl[i].e_sda_en);
      check1($sformatf("drv[%0d].sda_o", i), sda_o, tbl[i].e_sda_o);
      check1($sformatf("drv[%0d].ctrl_scl", i), ctrl_scl_o, tbl[i].e_cscl);
      check1($sformatf("drv[%0d].ctrl_sda", i), ctrl_sda_o, tbl[i].e_csda);
      check1($sformatf("drv[%0d].scl_o", i), scl_o, 1'b0);
    end
    ctrl_scl_i = 1'b1; ctrl_sda_i = 1'b1; pp_mode_i = 1'b0;
    repeat (2) tick();

    // Stuck detector: 20 low cycles, release, then reset mid-count.
    scl_i = 1'b0;
    stuck_run("stuck.hold", 1, 20, 19, 24);
    scl_i = 1'b1;
    stuck_run("stuck.release", 21, 26, 19, 24);
    repeat (4) tick();
    scl_i = 1'b0;
    repeat (10) tick();
    rst_ni = 1'b0;
    #2;
    check1("stuck.midreset.stuck", stuck_o, 1'b0);
    check1("stuck.midreset.ctrl_scl", ctrl_scl_o, 1'b1);
    #2;
    rst_ni = 1'b1;
    stuck_run("stuck.restart", 1, 22, 19, 1000);
    scl_i = 1'b1;
    repeat (6) tick();

    // Randomised run against the window-based reference model.
    scl_i = 1'b1; sda_i = 1'b1;
    ctrl_scl_i = 1'b1; ctrl_sda_i = 1'b1; pp_mode_i = 1'b0;
    filt_len_i = 4'd0;
    do_reset();
    fv_h[0][0] = 1'b1;
    fv_h[1][0] = 1'b1;
    t = 0;
    for (int seg = 0; seg < 5; seg++) begin
      for (int i = 0; i < 400; i++) begin
        t++;
        n = (segn[seg] < 0) ? int'($urandom_range(0, 6)) : segn[seg];
        filt_len_i = FCW'(n);
        if ($urandom_range(0, 5) == 0) scl_i = ~scl_i;
        if ($urandom_range(0, 5) == 0) sda_i = ~sda_i;
        if ($urandom_range(0, 9) == 0) ctrl_scl_i = ~ctrl_scl_i;
        if ($urandom_range(0, 9) == 0) ctrl_sda_i = ~ctrl_sda_i;
        if ($urandom_range(0, 29) == 0) pp_mode_i = ~pp_mode_i;
        pad_h[0][t] = scl_i;
        pad_h[1][t] = sda_i;
        cs = ctrl_scl_i; cd = ctrl_sda_i; pp = pp_mode_i;
        tick();

        for (int l = 0; l < 2; l++) begin
          seen_h[l][t] = (t - SS >= 1) ? pad_h[l][t - SS] : 1'b1;
          // fv flips once the last n+1 observed samples all disagree with it.
          mism = 1'b1;
          for (int k = t - n; k <= t; k++) begin
            if (((k >= 1) ? seen_h[l][k] : 1'b1) == fv_h[l][t - 1]) mism = 1'b0;
          end
          fv_h[l][t] = mism ? ~fv_h[l][t - 1] : fv_h[l][t - 1];
          e_r[l] = (t >= 2) && fv_h[l][t - 1] && !fv_h[l][t - 2];
          e_f[l] = (t >= 2) && !fv_h[l][t - 1] && fv_h[l][t - 2];
        end
        run = 0;
        for (int k = t - 1; k >= 0; k--) begin
          if (fv_h[0][k] || run >= STK) break;
          run++;
        end
`ifdef I3C_PHY_STUCK_DETECT_EN
        e_stuck = (run >= STK);
`else
        e_stuck = 1'b0;
`endif
        e_scl_en = ~cs;
        e_sda_en = pp | ~cd;
        e_sda_o  = pp & cd;
        e_vec = {1'b0, e_scl_en, e_sda_o, e_sda_en,
                 e_scl_en ? 1'b0 : fv_h[0][t],
                 (e_sda_en && !e_sda_o) ? 1'b0 : fv_h[1][t],
                 e_r[0], e_f[0], e_r[1], e_f[1], e_stuck};
        checkv($sformatf("rand.t%0d", t), outs(), e_vec);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
